regfile_bist: RTL and testbench

REGFILE_BIST -- requirements
Module: regfile_bist

---
 rtl/regfile_bist_pkg.sv | 38 +++
 rtl/regfile_bist_pattern.sv | 19 +
 rtl/regfile_bist.sv | 180 ++++++++++++++++++
 tb/tb_regfile_bist.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_bist_pkg.sv
// ---------------------------------------------------------------------------
// regfile_bist_pkg
// Shared definitions for the register-file built-in self test:
//   - register index / data widths of the 32 x 32 register file
//   - error counter width and saturation value
//   - BIST controller state encoding
//   - saturating error-count helper
// ---------------------------------------------------------------------------
package regfile_bist_pkg;

    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;
    localparam int ERR_W     = 5;

    localparam logic [ERR_W-1:0] ERR_MAX = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_e;

    // Add 0..2 mismatches to the error count, clamping at ERR_MAX.
    function automatic logic [ERR_W-1:0] err_sat_add(
        input logic [ERR_W-1:0] cnt,
        input logic [1:0]       inc
    );
        logic [ERR_W:0] sum;
        sum = {1'b0, cnt} + {4'd0, inc};
        if (sum > {1'b0, ERR_MAX}) begin
            return ERR_MAX;
        end else begin
            return sum[ERR_W-1:0];
        end
    endfunction

endpackage

// File: rtl/regfile_bist_pattern.sv
// ---------------------------------------------------------------------------
// bist_pattern
// Combinational data-pattern generator: pattern = SEED + index (mod 2^32).
// Ports:
//   index   in  [4:0]   register index
//   pattern out [31:0]  expected / written data for that register
// ---------------------------------------------------------------------------
module bist_pattern
    import regfile_bist_pkg::*;
#(
    parameter logic [DATA_W-1:0] SEED = 32'hA5A5_0000
) (
    input  logic [REG_IDX_W-1:0] index,
    output logic [DATA_W-1:0]    pattern
);

    assign pattern = SEED + {{(DATA_W-REG_IDX_W){1'b0}}, index};

endmodule

// File: rtl/regfile_bist.sv
// ---------------------------------------------------------------------------
// regfile_bist
// Self test for a 2-read / 1-write register file. Writes SEED+i to registers
// FIRST_REG..LAST_REG, then reads them back in pairs from both ends
// (lo ascending on port 1, hi descending on port 2), counting mismatches.
// Ports:
//   Clk, Reset (sync, active-high), Start
//   Busy, Done (1-cycle pulse), Pass, ErrCount[4:0], FirstFailReg[4:0]
//   WriteRegister[4:0], WriteData[31:0], RegWrite      -> register file
//   ReadRegister1[4:0], ReadRegister2[4:0]              -> register file
//   ReadData1[31:0], ReadData2[31:0]                    <- register file
// All outputs are registered.
// ---------------------------------------------------------------------------
module regfile_bist
    import regfile_bist_pkg::*;
#(
    parameter logic [REG_IDX_W-1:0] FIRST_REG = 5'd8,
    parameter logic [REG_IDX_W-1:0] LAST_REG  = 5'd25,
    parameter logic [DATA_W-1:0]    SEED      = 32'hA5A5_0000
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Pass,
    output logic [ERR_W-1:0]     ErrCount,
    output logic [REG_IDX_W-1:0] FirstFailReg,
    output logic [REG_IDX_W-1:0] WriteRegister,
    output logic [DATA_W-1:0]    WriteData,
    output logic                 RegWrite,
    output logic [REG_IDX_W-1:0] ReadRegister1,
    output logic [REG_IDX_W-1:0] ReadRegister2,
    input  logic [DATA_W-1:0]    ReadData1,
    input  logic [DATA_W-1:0]    ReadData2
);

    bist_state_e           state_r, state_s;
    logic                  busy_r, busy_s;
    logic                  done_r, done_s;
    logic                  pass_r, pass_s;
    logic [ERR_W-1:0]      err_r, err_s;
    logic [REG_IDX_W-1:0]  ffr_r, ffr_s;
    logic [REG_IDX_W-1:0]  wreg_r, wreg_s;
    logic [DATA_W-1:0]     wdata_r, wdata_s;
    logic                  regwrite_r, regwrite_s;
    logic [REG_IDX_W-1:0]  lo_r, lo_s;
    logic [REG_IDX_W-1:0]  hi_r, hi_s;

    logic [REG_IDX_W-1:0]  wr_idx_s;
    logic [DATA_W-1:0]     wr_pat_s;
    logic [DATA_W-1:0]     exp1_s;
    logic [DATA_W-1:0]     exp2_s;
    logic                  mism1_s;
    logic                  mism2_s;
    logic                  last_pair_s;

    // Index of the next write: first register when leaving IDLE, else the
    // successor of the register being written now. Kept outside the FSM
    // process so the write pattern does not feed back into it.
    assign wr_idx_s = (state_r == ST_IDLE) ? FIRST_REG : (wreg_r + 5'd1);

    bist_pattern #(.SEED(SEED)) u_pat_wr  (.index(wr_idx_s), .pattern(wr_pat_s));
    bist_pattern #(.SEED(SEED)) u_pat_rd1 (.index(lo_r),     .pattern(exp1_s));
    bist_pattern #(.SEED(SEED)) u_pat_rd2 (.index(hi_r),     .pattern(exp2_s));

    assign mism1_s = (ReadData1 != exp1_s);
    assign mism2_s = (ReadData2 != exp2_s);

    // Pointers meeting (odd count) or adjacent (even count) mark the final
    // read pair; both cases take ceil(N/2) read cycles in total.
    assign last_pair_s = (({1'b0, lo_r} + 6'd1) >= {1'b0, hi_r});

    // Next-state and next-output logic of the BIST controller.
    always_comb begin
        state_s    = state_r;
        busy_s     = 1'b0;
        done_s     = 1'b0;
        regwrite_s = 1'b0;
        pass_s     = pass_r;
        err_s      = err_r;
        ffr_s      = ffr_r;
        wreg_s     = wreg_r;
        wdata_s    = wdata_r;
        lo_s       = lo_r;
        hi_s       = hi_r;
        case (state_r)
            ST_IDLE: begin
                if (Start) begin
                    state_s    = ST_WRITE;
                    busy_s     = 1'b1;
                    regwrite_s = 1'b1;
                    wreg_s     = wr_idx_s;
                    wdata_s    = wr_pat_s;
                    pass_s     = 1'b0;
                    err_s      = 5'd0;
                    ffr_s      = 5'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                busy_s = 1'b1;
                if (wreg_r >= LAST_REG) begin
                    state_s = ST_READ;
                    lo_s    = FIRST_REG;
                    hi_s    = LAST_REG;
                end else begin
                    regwrite_s = 1'b1;
                    wreg_s     = wr_idx_s;
                    wdata_s    = wr_pat_s;
                end
            end
            ST_READ: begin
                err_s = err_sat_add(err_r, {1'b0, mism1_s} + {1'b0, mism2_s});
                if (mism1_s && mism2_s && (err_r == 5'd0)) begin
                    ffr_s = lo_r;
                end else begin
                    ffr_s = ffr_r;
                end
                if (last_pair_s) begin
                    state_s = ST_DONE;
                    done_s  = 1'b1;
                    pass_s  = (err_s == 5'd0);
                end else begin
                    busy_s = 1'b1;
                    lo_s   = lo_r + 5'd1;
                    hi_s   = hi_r - 5'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            err_r      <= 5'd0;
            ffr_r      <= 5'd0;
            wreg_r     <= 5'd0;
            wdata_r    <= 32'd0;
            regwrite_r <= 1'b0;
            lo_r       <= 5'd0;
            hi_r       <= 5'd0;
        end else begin
            state_r    <= state_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            pass_r     <= pass_s;
            err_r      <= err_s;
            ffr_r      <= ffr_s;
            wreg_r     <= wreg_s;
            wdata_r    <= wdata_s;
            regwrite_r <= regwrite_s;
            lo_r       <= lo_s;
            hi_r       <= hi_s;
        end
    end

    assign Busy          = busy_r;
    assign Done          = done_r;
    assign Pass          = pass_r;
    assign ErrCount      = err_r;
    assign FirstFailReg  = ffr_r;
    assign WriteRegister = wreg_r;
    assign WriteData     = wdata_r;
    assign RegWrite      = regwrite_r;
    assign ReadRegister1 = lo_r;
    assign ReadRegister2 = hi_r;

endmodule

// File: tb/tb_regfile_bist.sv
// ---------------------------------------------------------------------------
// tb_regfile_bist
// Three BIST instances (8..25, 8..12, 1..31) each attached to a behavioural
// 32 x 32 register file (register 0 reads zero, combinational reads).
// A cycle-indexed model predicts every output from the test schedule;
// directed tests add literal expectations for latency, data and results.
// ---------------------------------------------------------------------------
module tb_regfile_bist;

    localparam int          NDUT = 3;
    localparam logic [31:0] SEED = 32'hA5A5_0000;
    localparam int          FR [NDUT] = '{8, 8, 1};
    localparam int          LR [NDUT] = '{25, 12, 31};

    logic clk = 1'b0;
    logic Reset;
    logic Start;
    logic flip20;
    logic corrupt_all;

    logic        busy     [NDUT];
    logic        done     [NDUT];
    logic        pass     [NDUT];
    logic [4:0]  errc     [NDUT];
    logic [4:0]  ffr      [NDUT];
    logic [4:0]  wreg     [NDUT];
    logic [31:0] wdata    [NDUT];
    logic        regwrite [NDUT];
    logic [4:0]  rr1      [NDUT];
    logic [4:0]  rr2      [NDUT];

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        logic [31:0] rf [32];
        logic [31:0] rd1;
        logic [31:0] rd2;

        regfile_bist #(
            .FIRST_REG(5'(FR[g])),
            .LAST_REG (5'(LR[g])),
            .SEED     (SEED)
        ) u_dut (
            .Clk          (clk),
            .Reset        (Reset),
            .Start        (Start),
            .Busy         (busy[g]),
            .Done         (done[g]),
            .Pass         (pass[g]),
            .ErrCount     (errc[g]),
            .FirstFailReg (ffr[g]),
            .WriteRegister(wreg[g]),
            .WriteData    (wdata[g]),
            .RegWrite     (regwrite[g]),
            .ReadRegister1(rr1[g]),
            .ReadRegister2(rr2[g]),
            .ReadData1    (rd1),
            .ReadData2    (rd2)
        );

        always @(posedge clk) begin
            if (regwrite[g] && (wreg[g] != 5'd0)) begin
                rf[wreg[g]] <= wdata[g];
            end
        end

        always_comb begin
            rd1 = (rr1[g] == 5'd0) ? 32'd0 : rf[rr1[g]];
            rd2 = (rr2[g] == 5'd0) ? 32'd0 : rf[rr2[g]];
            rd1 = rd1 ^ {31'd0, corrupt_all};
            rd2 = rd2 ^ {31'd0, (corrupt_all || (flip20 && (rr2[g] == 5'd20)))};
        end
    end

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, g, $time, act, exp);
        end
    endtask

    // Expected result of one full test, walking the read pairs from both ends
    // until the pointers cross, with the bench's own fault injection applied.
    function automatic void calc(input int f, input int l, input bit fl, input bit ca,
                                 output int err, output int ffr_o);
        int lo;
        int hi;
        logic [31:0] want1, want2, got1, got2;
        bit m1, m2;
        err = 0; ffr_o = 0; lo = f; hi = l;
        while (lo <= hi) begin
            want1 = SEED + 32'(lo);
            want2 = SEED + 32'(hi);
            got1  = (lo == 0) ? 32'd0 : want1;
            got2  = (hi == 0) ? 32'd0 : want2;
            if (ca) begin
                got1 = got1 ^ 32'd1;
                got2 = got2 ^ 32'd1;
            end
            if (fl && (hi == 20)) got2 = got2 ^ 32'd1;
            m1 = (got1 != want1);
            m2 = (got2 != want2);
            if (m1 && m2 && (err == 0)) ffr_o = lo;
            err = err + int'(m1) + int'(m2);
            if (err > 31) err = 31;
            lo++;
            hi--;
        end
    endfunction

    // Model: t = cycle number within a running test (1..N WRITE,
    // N+1..N+R READ, N+R+1 DONE), 0 when idle.
    int t         [NDUT];
    bit after_rst [NDUT];
    int m_err     [NDUT];
    int m_ffr     [NDUT];
    bit m_pass    [NDUT];

    always @(posedge clk) begin
        for (int g = 0; g < NDUT; g++) begin
            int n, r, tot;
            n = LR[g] - FR[g] + 1;
            r = (n + 1) / 2;
            tot = n + r + 1;
            if (Reset) begin
                t[g] = 0; after_rst[g] = 1'b1;
                m_err[g] = 0; m_ffr[g] = 0; m_pass[g] = 1'b0;
            end else if (t[g] == 0) begin
                if (Start) begin
                    t[g] = 1; after_rst[g] = 1'b0;
                    m_err[g] = 0; m_ffr[g] = 0; m_pass[g] = 1'b0;
                end
            end else if (t[g] == tot) begin
                t[g] = 0;
            end else begin
                t[g] = t[g] + 1;
                if (t[g] == tot) begin
                    calc(FR[g], LR[g], flip20, corrupt_all, m_err[g], m_ffr[g]);
                    m_pass[g] = (m_err[g] == 0);
                end
            end
        end
    end

    // Compare every meaningful output against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int g = 0; g < NDUT; g++) begin
                int n, r, k;
                n = LR[g] - FR[g] + 1;
                r = (n + 1) / 2;
                chk("busy", g, 32'(busy[g]), 32'((t[g] >= 1) && (t[g] <= n + r)));
                chk("regwrite", g, 32'(regwrite[g]), 32'((t[g] >= 1) && (t[g] <= n)));
                chk("done", g, 32'(done[g]), 32'(t[g] == n + r + 1));
                if (t[g] == 0 || t[g] == n + r + 1) begin
                    chk("errcount", g, 32'(errc[g]), 32'(m_err[g]));
                    chk("firstfail", g, 32'(ffr[g]), 32'(m_ffr[g]));
                    chk("pass", g, 32'(pass[g]), 32'(m_pass[g]));
                    if (after_rst[g]) begin
                        chk("rst_wreg", g, 32'(wreg[g]), 32'd0);
                        chk("rst_wdata", g, wdata[g], 32'd0);
                        chk("rst_rr1", g, 32'(rr1[g]), 32'd0);
                        chk("rst_rr2", g, 32'(rr2[g]), 32'd0);
                    end
                end else if (t[g] <= n) begin
                    chk("wreg", g, 32'(wreg[g]), 32'(FR[g] + t[g] - 1));
                    chk("wdata", g, wdata[g], SEED + 32'(FR[g] + t[g] - 1));
                    chk("err_clear", g, 32'(errc[g]), 32'd0);
                    chk("ffr_clear", g, 32'(ffr[g]), 32'd0);
                end else begin
                    k = t[g] - n - 1;
                    chk("rr1", g, 32'(rr1[g]), 32'(FR[g] + k));
                    chk("rr2", g, 32'(rr2[g]), 32'(LR[g] - k));
                end
            end
        end
    end

    int          lat [NDUT];
    logic [31:0] first_wd;
    logic [4:0]  pair0 [2];
    logic [4:0]  pair1 [2];

    // Pulse Start and watch 80 cycles; cycle 1 is the one after the Start
    // edge, so lat[g] is the cycle number in which Done is high.
    task automatic pulse_and_wait();
        Start = 1'b1;
        @(posedge clk);
        #1 Start = 1'b0;
        for (int g = 0; g < NDUT; g++) lat[g] = -1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (c == 1) first_wd = wdata[0];
            if (c == 27) begin pair0[0] = rr1[0]; pair0[1] = rr2[0]; end
            if (c == 8)  begin pair1[0] = rr1[1]; pair1[1] = rr2[1]; end
            for (int g = 0; g < NDUT; g++) begin
                if (done[g] && (lat[g] < 0)) lat[g] = c;
            end
        end
    endtask

    initial begin
        int ndone;
        int d1, d2;
        Reset = 1'b1; Start = 1'b0; flip20 = 1'b0; corrupt_all = 1'b0;
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(posedge clk);
        #1 Reset = 1'b0;

        // Clean run on all three ranges.
        pulse_and_wait();
        chk("lat_default", 0, 32'(lat[0]), 32'd28);
        chk("lat_odd", 1, 32'(lat[1]), 32'd9);
        chk("lat_wide", 2, 32'(lat[2]), 32'd48);
        chk("first_wdata", 0, first_wd, 32'hA5A5_0008);
        chk("last_pair_lo", 0, 32'(pair0[0]), 32'd16);
        chk("last_pair_hi", 0, 32'(pair0[1]), 32'd17);
        chk("odd_pair_lo", 1, 32'(pair1[0]), 32'd10);
        chk("odd_pair_hi", 1, 32'(pair1[1]), 32'd10);
        chk("clean_pass", 0, 32'(pass[0]), 32'd1);
        chk("clean_err", 0, 32'(errc[0]), 32'd0);
        chk("clean_pass_odd", 1, 32'(pass[1]), 32'd1);

        // Single-port fault on register 20 read through port 2.
        flip20 = 1'b1;
        pulse_and_wait();
        flip20 = 1'b0;
        chk("flip_err", 0, 32'(errc[0]), 32'd1);
        chk("flip_ffr", 0, 32'(ffr[0]), 32'd0);
        chk("flip_pass", 0, 32'(pass[0]), 32'd0);

        // Both ports corrupted on every read.
        corrupt_all = 1'b1;
        pulse_and_wait();
        corrupt_all = 1'b0;
        chk("all_err", 0, 32'(errc[0]), 32'd18);
        chk("all_ffr", 0, 32'(ffr[0]), 32'd8);
        chk("all_err_odd", 1, 32'(errc[1]), 32'd6);
        chk("all_err_sat", 2, 32'(errc[2]), 32'd31);
        chk("all_ffr_wide", 2, 32'(ffr[2]), 32'd1);

        // Reset during the 10th WRITE cycle aborts the test.
        Start = 1'b1;
        @(posedge clk);
        #1 Start = 1'b0;
        repeat (9) @(posedge clk);
        #1 Reset = 1'b1;
        @(posedge clk);
        #1 Reset = 1'b0;
        @(negedge clk);
        chk("abort_regwrite", 0, 32'(regwrite[0]), 32'd0);
        chk("abort_busy", 0, 32'(busy[0]), 32'd0);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done[0]) ndone++;
        end
        chk("abort_no_done", 0, 32'(ndone), 32'd0);
        pulse_and_wait();
        chk("after_abort_lat", 0, 32'(lat[0]), 32'd28);
        chk("after_abort_pass", 0, 32'(pass[0]), 32'd1);

        // Start held high: one test per IDLE entry, Done every 29 cycles.
        Start = 1'b1;
        ndone = 0; d1 = -1; d2 = -1;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (done[0]) begin
                ndone++;
                if (d1 < 0) d1 = c;
                else if (d2 < 0) d2 = c;
            end
        end
        Start = 1'b0;
        chk("held_done_count", 0, 32'(ndone), 32'd2);
        chk("held_first_done", 0, 32'(d1), 32'd28);
        chk("held_spacing", 0, 32'(d2 - d1), 32'd29);
        repeat (80) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
